// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the benches that drive it.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } gen_state_t;

  localparam int DEFAULT_MAX_LEN = 8;

  // Reference pattern used by the detector benches.
  localparam logic [3:0] PAT_0011     = 4'b0011;
  localparam int         PAT_0011_LEN = 4;

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable left-shift register with a down-counting bit counter.
// The pattern is left-aligned on load so dout is always the bit currently on the line.
module seq_gen_shreg
  import seq_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] din,
  input  logic [LEN_W-1:0]   len,
  output logic               dout,
  output logic               last
);

  logic [MAX_LEN-1:0] sr;
  logic [LEN_W-1:0]   cnt;

  // Left alignment drops unused pattern bits and leaves zeros behind, so the
  // register reads 0 once the final bit has been shifted out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= din << (MAX_LEN - int'(len));
      cnt <= len;
    end else if (shift) begin
      sr  <= sr << 1;
      cnt <= cnt - LEN_W'(1);
    end
  end

  assign dout = sr[MAX_LEN-1];
  assign last = (cnt == LEN_W'(1));

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: loads a pattern over a valid/ready port and
// shifts it out MSB-first, with repeat count and inter-repetition gap.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int REP_W   = 4,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   reps,
  input  logic [GAP_W-1:0]   gap,
  output logic               out,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
  localparam logic [1:0] ST_GAP   = 2'(GAP);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  logic [1:0]         state, state_n;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q, len_c;
  logic [GAP_W-1:0]   gap_q, gap_cnt;
  logic [REP_W-1:0]   rep_cnt, reps_c;
  logic               accept, more_reps, rep_end;
  logic               sr_load, sr_shift, sr_last;
  logic [MAX_LEN-1:0] sr_din;
  logic [LEN_W-1:0]   sr_len;

  assign load_ready = (state == ST_IDLE);
  assign accept     = load_valid && load_ready;
  assign len_c      = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign reps_c     = (reps == '0) ? REP_W'(1) : reps;
  assign more_reps  = (rep_cnt > REP_W'(1));
  assign rep_end    = (state == ST_SHIFT) && sr_last;

  // Fresh loads come straight from the port; repeats reload from the held copy.
  assign sr_din = (state == ST_IDLE) ? pattern : pat_q;
  assign sr_len = (state == ST_IDLE) ? len_c : len_q;

  seq_gen_shreg #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (sr_load),
    .shift(sr_shift),
    .din  (sr_din),
    .len  (sr_len),
    .dout (out),
    .last (sr_last)
  );

  always_comb begin
    state_n  = state;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (len_c != '0) begin
            state_n = ST_SHIFT;
            sr_load = 1'b1;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (!sr_last) begin
          sr_shift = 1'b1;
        end else if (more_reps && gap_q != '0) begin
          state_n  = ST_GAP;
          sr_shift = 1'b1;
        end else if (more_reps) begin
          sr_load = 1'b1;
        end else begin
          state_n  = ST_DONE;
          sr_shift = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_n = ST_SHIFT;
          sr_load = 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      rep_cnt   <= '0;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= (state_n == ST_SHIFT);
      busy      <= (state_n != ST_IDLE);
      done      <= (state_n == ST_DONE);
      if (accept) begin
        pat_q   <= pattern;
        len_q   <= len_c;
        gap_q   <= gap;
        rep_cnt <= reps_c;
      end else if (rep_end && more_reps) begin
        rep_cnt <= rep_cnt - REP_W'(1);
      end
      if (rep_end && more_reps && gap_q != '0) begin
        gap_cnt <= gap_q;
      end else if (state == ST_GAP && gap_cnt > GAP_W'(1)) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial bit-pattern transmitter that produces the bitstreams our sequence detectors consume. It accepts a pattern word, length, repeat count and inter-repetition gap over a valid/ready load port. It then shifts the pattern out MSB-first, one bit per clock, with a qualifying valid strobe. It feeds the detector bench and on-chip self-test paths.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits (≥2).
- LEN_W, default $clog2(MAX_LEN+1): width of the length field.
- REP_W, default 4: width of the repeat-count field.
- GAP_W, default 4: width of the gap field.

Reset is rst, asynchronous, active-high; the clock is clk.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- load_valid  in  1  load request.
- load_ready  out  1  high only in IDLE; a load is accepted on a cycle with load_valid && load_ready.
- pattern  in  MAX_LEN  pattern bits; the first bit sent is pattern[len-1].
- len  in  LEN_W  number of bits per repetition. 0 means no bits are sent; values above MAX_LEN are clamped to MAX_LEN.
- reps  in  REP_W  number of repetitions; 0 is treated as 1.
- gap  in  GAP_W  idle cycles between repetitions. There is no gap after the last repetition.
- out  out  1  serial data. Registered; 0 whenever out_valid=0.
- out_valid  out  1  out carries a pattern bit this cycle.
- busy  out  1  high in SHIFT, GAP and DONE.
- done  out  1  one-cycle pulse when the whole transfer completes.

## Operation
- **States:** IDLE, SHIFT, GAP, DONE.
- **IDLE:** load_ready=1. On accept, register pattern, len (clamped), reps (0→1) and gap.
  - len≠0 → SHIFT.
  - len=0 → DONE.
- **SHIFT:** each cycle drive out = the current bit, out_valid=1, decrement the bit counter. After the last bit of a repetition:
  - Remaining reps >0 and gap>0 → GAP.
  - Remaining reps >0 and gap=0 → SHIFT. The next repetition starts with no bubble and the shift register reloads from the held pattern.
  - Otherwise → DONE.
- **GAP:** out=0, out_valid=0 for exactly gap cycles, then → SHIFT with a reloaded pattern.
- **DONE:** done=1 for one cycle, out_valid=0, then → IDLE.
- **Load port:** load_valid is ignored outside IDLE, so input fields may change freely while busy.
- **Counters:**
  - Bit counter is LEN_W wide and counts down from len.
  - Rep counter is REP_W wide and counts down from reps.
  - Gap counter is GAP_W wide.
  - No counter wraps: each is reloaded before reaching 0-1.
- **Reset:** async rst, including mid-transfer, forces IDLE immediately. All outputs go to 0 except load_ready=1. No done pulse is issued for the aborted transfer, and no partial bits are produced after rst deasserts.

## Timing
- **Accept at clock edge k:** first bit appears on out and out_valid from edge k+1.
- **Busy duration:** busy stays high for len·reps + gap·(reps−1) + 1 cycles after the accept edge. The final one of those cycles is DONE.
- **Back-to-back loads:** load_ready rises the cycle after DONE, so the minimum spacing between accepts is the transfer time + 1 cycle.
- **len=0:** accept → DONE next cycle → IDLE. out_valid never asserts.
- **Output registering:** all outputs are registered except load_ready, which is decoded from the state register.

## Structure
- **Shared package seq_pkg:**
  - state enum gen_state_t {IDLE, SHIFT, GAP, DONE}.
  - default MAX_LEN.
  - constant PAT_0011 = 4'b0011 with length 4, used by benches.
- **Sub-module seq_gen_shreg:** MAX_LEN-bit loadable left-shift register plus bit-count-down. Ports: load, shift, din, len, dout, last.
  - The top level owns the FSM and the rep and gap counters.
- Target size: roughly 200 lines.

## Test plan
- **Single pattern:** pattern=4'b0011, len=4, reps=1, gap=0 → out = 0,0,1,1 on cycles k+1..k+4 with out_valid=1; done at k+5; load_ready=1 at k+6.
- **Repeats with gap:** pattern=3'b101, len=3, reps=2, gap=2 → out_valid pattern 1,1,1,0,0,1,1,1; data 1,0,1,–,–,1,0,1; done on the 9th cycle.
- **Boundaries:**
  - len=0 → done one cycle after accept, no out_valid.
  - len=15 with MAX_LEN=8 → exactly 8 bits, pattern[7] first.
  - reps=0 → single repetition.
- **Back-to-back, no gap:** reps=3, gap=0, len=2, pattern=2'b10 → continuous 1,0,1,0,1,0 with no bubble. A load_valid held high throughout is accepted only after done.
- **Reset mid-transfer:** assert rst during the second bit of an 8-bit transfer → outputs 0 asynchronously, no done. After release, load_ready=1 and a new load transmits correctly.
